// File: rtl/io_mux_pkg.sv
// Shared definitions for the pad multiplexer: config layout, function codes
// and the alternate-function slot mapping.
package io_mux_pkg;

  localparam int FUNC_LSB     = 0;
  localparam int FUNC_W       = 2;
  localparam int FILTER_BIT   = 4;
  localparam int LOCK_BIT     = 7;
  localparam int FILTER_CNT_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_GPIO = 2'd0;

  typedef struct packed {
    logic              lock;
    logic              filter_en;
    logic [FUNC_W-1:0] func;
  } pin_cfg_t;

  // Alternate slots are packed per pin; function 0 (GPIO) has no slot.
  function automatic int slot_index(input int pin, input int func, input int func_count);
    return pin * (func_count - 1) + func - 1;
  endfunction

  function automatic logic [7:0] cfg_to_byte(input pin_cfg_t c);
    logic [7:0] b;
    b = '0;
    b[FUNC_LSB +: FUNC_W] = c.func;
    b[FILTER_BIT]         = c.filter_en;
    b[LOCK_BIT]           = c.lock;
    return b;
  endfunction

  function automatic pin_cfg_t byte_to_cfg(input logic [7:0] b);
    pin_cfg_t c;
    c.func      = b[FUNC_LSB +: FUNC_W];
    c.filter_en = b[FILTER_BIT];
    c.lock      = b[LOCK_BIT];
    return c;
  endfunction

endpackage

// File: rtl/io_mux_pin_filter.sv
// Per-pin input conditioning: synchroniser chain followed by an optional
// glitch filter that only follows input changes stable for FILTER_LEN cycles.
module io_mux_pin_filter
  import io_mux_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  input  logic filter_en,
  output logic filt_out
);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;
  logic                    filt_q, filt_d;
  logic                    en_q, en_d;
  logic                    synced;

  // Unknown pad levels are forced to 0 on entry so X never propagates inward.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], (pad_in === 1'b1)};
    synced = sync_q[SYNC_STAGES-1];
    en_d   = filter_en;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (!filter_en || !en_q) begin
      filt_d = synced;
      cnt_d  = '0;
    end else if (synced == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FILTER_CNT_W'(FILTER_LEN - 1)) begin
      filt_d = synced;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FILTER_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      en_q   <= en_d;
    end
  end

  assign filt_out = filter_en ? filt_q : synced;

endmodule

// File: rtl/io_mux_matrix.sv
// Runtime-programmable pad multiplexer: per-pin function select, input
// filtering and lockable configuration behind a simple strobe/ack bus.
module io_mux_matrix
  import io_mux_pkg::*;
#(
  parameter  int PIN_COUNT   = 38,
  parameter  int FUNC_COUNT  = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILTER_LEN  = 4,
  localparam int ALTW        = PIN_COUNT * (FUNC_COUNT - 1),
  localparam int AW          = $clog2(PIN_COUNT),
  parameter  logic [ALTW-1:0] ALT_IN_IDLE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        cfg_addr,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_rd_en,
  input  logic [7:0]           cfg_wdata,
  output logic [7:0]           cfg_rdata,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  input  logic [PIN_COUNT-1:0] gpio_output,
  input  logic [PIN_COUNT-1:0] gpio_oeb,
  output logic [PIN_COUNT-1:0] gpio_input,
  input  logic [ALTW-1:0]      alt_out,
  input  logic [ALTW-1:0]      alt_oeb,
  output logic [ALTW-1:0]      alt_in,
  input  logic [PIN_COUNT-1:0] io_in,
  output logic [PIN_COUNT-1:0] io_out,
  output logic [PIN_COUNT-1:0] io_oeb
);

  localparam logic [AW:0] PIN_LIMIT = (AW + 1)'(PIN_COUNT);

  pin_cfg_t cfg_q [PIN_COUNT];
  pin_cfg_t cfg_d [PIN_COUNT];
  logic [7:0] rdata_q, rdata_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic       addr_ok;
  logic       wr_reject;
  pin_cfg_t   cur_cfg;
  pin_cfg_t   wr_cfg;
  logic [PIN_COUNT-1:0] filt;

  // Reads sample the pre-write register, so a combined read+write returns old data.
  always_comb begin
    addr_ok   = ({1'b0, cfg_addr} < PIN_LIMIT);
    cur_cfg   = addr_ok ? cfg_q[cfg_addr] : '0;
    wr_cfg    = byte_to_cfg(cfg_wdata);
    wr_reject = !addr_ok || cur_cfg.lock || (int'(wr_cfg.func) >= FUNC_COUNT);

    cfg_d = cfg_q;
    if (cfg_wr_en && !wr_reject) begin
      cfg_d[cfg_addr] = wr_cfg;
    end

    ack_d   = cfg_wr_en || cfg_rd_en;
    err_d   = (cfg_wr_en && wr_reject) || (cfg_rd_en && !addr_ok);
    rdata_d = cfg_rd_en ? cfg_to_byte(cur_cfg) : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PIN_COUNT; p++) begin
        cfg_q[p] <= '0;
      end
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign cfg_rdata = rdata_q;
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;

  for (genvar p = 0; p < PIN_COUNT; p++) begin : g_pin
    io_mux_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .pad_in   (io_in[p]),
      .filter_en(cfg_q[p].filter_en),
      .filt_out (filt[p])
    );
  end

  // Selection is driven only by registered config, so pads never see a
  // transient function code while the bus is being written.
  always_comb begin
    alt_in = ALT_IN_IDLE;
    for (int p = 0; p < PIN_COUNT; p++) begin
      io_out[p]     = gpio_output[p];
      io_oeb[p]     = gpio_oeb[p];
      gpio_input[p] = (cfg_q[p].func == FUNC_GPIO) ? filt[p] : 1'b0;
      for (int f = 1; f < FUNC_COUNT; f++) begin
        if (cfg_q[p].func == FUNC_W'(f)) begin
          io_out[p] = alt_out[slot_index(p, f, FUNC_COUNT)];
          io_oeb[p] = alt_oeb[slot_index(p, f, FUNC_COUNT)];
          alt_in[slot_index(p, f, FUNC_COUNT)] = filt[p];
        end
      end
    end
  end

endmodule
